ctrl_trace_encoder: RTL

//  Re-encodes the per-cycle decoded control bundle back into MIPS op/func fields.

---
 rtl/ctrl_trace_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes the decoded control bundle of each committing instruction into MIPS op/func
// and queues {ts, pc, op, func, bad} records for a valid/ready trace consumer.
module ctrl_trace_encoder #(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit_en,
    input  logic [31:0]              pc,
    input  logic                     RegWr,
    input  logic                     ALUSrc,
    input  logic                     RegDst,
    input  logic                     MemtoReg,
    input  logic                     MemWr,
    input  logic                     Branch,
    input  logic                     Jump,
    input  logic                     Extop,
    input  logic [3:0]               ALUctr,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [TS_W-1:0]          trace_ts,
    output logic [31:0]              trace_pc,
    output logic [5:0]               trace_op,
    output logic [5:0]               trace_func,
    output logic                     trace_bad,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [31:0]     pc;
        logic [5:0]      op;
        logic [5:0]      func;
        logic            bad;
    } rec_t;

    logic [5:0] enc_op;
    logic [5:0] enc_func;
    logic       enc_bad;
    logic [2:0] ctl_hot;

    // Priority encoder; anything that falls through keeps the illegal default.
    always_comb begin
        enc_op   = 6'b111111;
        enc_func = 6'b000000;
        enc_bad  = 1'b1;
        ctl_hot  = 3'(Jump) + 3'(Branch) + 3'(MemWr) + 3'(MemtoReg);
        if (ctl_hot > 3'd1) begin
            enc_bad = 1'b1;
        end else if (Jump) begin
            enc_op  = 6'b000010;
            enc_bad = 1'b0;
        end else if (Branch && ALUctr == 4'b0001) begin
            enc_op  = 6'b000100;
            enc_bad = 1'b0;
        end else if (MemWr && ALUSrc && ALUctr == 4'b0000) begin
            enc_op  = 6'b101011;
            enc_bad = 1'b0;
        end else if (MemtoReg && RegWr && ALUSrc && ALUctr == 4'b0000) begin
            enc_op  = 6'b100011;
            enc_bad = 1'b0;
        end else if (RegWr && RegDst && !ALUSrc) begin
            enc_bad = 1'b0;
            enc_op  = 6'b000000;
            case (ALUctr)
                4'b0000: enc_func = 6'b100000;
                4'b0001: enc_func = 6'b100010;
                4'b0010: enc_func = 6'b100100;
                4'b0011: enc_func = 6'b100101;
                4'b0100: enc_func = 6'b101010;
                default: begin
                    enc_op  = 6'b111111;
                    enc_bad = 1'b1;
                end
            endcase
        end else if (RegWr && !RegDst && ALUSrc && Extop && ALUctr == 4'b0000) begin
            enc_op  = 6'b001001;
            enc_bad = 1'b0;
        end else if (RegWr && !RegDst && ALUSrc && !Extop && ALUctr == 4'b0011) begin
            enc_op  = 6'b001101;
            enc_bad = 1'b0;
        end else if (!RegWr && !MemWr && !Branch && !Jump) begin
            enc_op  = 6'b000000;
            enc_bad = 1'b0;
        end
    end

    rec_t              mem [DEPTH];
    rec_t              head_reg, head_next, new_rec;
    logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [LW-1:0]     level_reg, level_next;
    logic [DROP_W-1:0] drop_reg;
    logic [TS_W-1:0]   ts_reg;
    logic              full, pop, push;

    assign full        = (level_reg == LW'(DEPTH));
    assign trace_valid = (level_reg != '0);
    assign pop         = trace_valid && trace_ready;
    assign push        = commit_en && (!full || pop);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);
    assign level_next  = level_reg + LW'(push) - LW'(pop);
    assign new_rec     = '{ts: ts_reg, pc: pc, op: enc_op, func: enc_func, bad: enc_bad};

    // The new head either already sits in storage or is the record being written now.
    always_comb begin
        head_next = head_reg;
        if (level_next != '0) begin
            if (level_reg == LW'(pop) && push)
                head_next = new_rec;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr_reg] <= new_rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            drop_reg   <= '0;
            ts_reg     <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            level_reg  <= level_next;
            ts_reg     <= ts_reg + 1'b1;
            head_reg   <= head_next;
            if (commit_en && !push && drop_reg != '1)
                drop_reg <= drop_reg + 1'b1;
        end
    end

    assign trace_ts   = head_reg.ts;
    assign trace_pc   = head_reg.pc;
    assign trace_op   = head_reg.op;
    assign trace_func = head_reg.func;
    assign trace_bad  = head_reg.bad;
    assign fifo_level = level_reg;
    assign drop_cnt   = drop_reg;

endmodule
